// File: rtl/us_timer_bank.sv
// Bank of independent microsecond timers: each channel counts clk cycles into
// microseconds and pulses done_o after the latched duration, one-shot or auto-reload.
module us_timer_bank #(
    parameter int  CLK_FREQ = 100_000_000,
    parameter int  NUM_CH   = 4,
    parameter int  MAX_US   = 1000,
    localparam int W        = $clog2(MAX_US + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   start_i,
    input  logic [NUM_CH-1:0]   stop_i,
    input  logic [NUM_CH-1:0]   periodic_i,
    input  logic [NUM_CH*W-1:0] dur_i,
    output logic [NUM_CH-1:0]   busy_o,
    output logic [NUM_CH-1:0]   done_o,
    output logic [NUM_CH-1:0]   err_o
);

    localparam int             CYC      = CLK_FREQ / 1_000_000;
    localparam int             PW       = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(CYC - 1);
    localparam logic [W-1:0]   DUR_MAX  = W'(MAX_US);

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } state_t;

    function automatic logic [W-1:0] sat_dur(input logic [W-1:0] d);
        return (d > DUR_MAX) ? DUR_MAX : d;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t        state_q;
        logic [PW-1:0] pre_q;
        logic [W-1:0]  us_q;
        logic [W-1:0]  dur_q;
        logic          mode_q;
        logic          done_q;
        logic          err_q;

        logic [W-1:0]  dur_d;
        logic          start_ok_d;
        logic          expire_d;

        // Expiry is detected on the last cycle of the period so done_q rises
        // exactly D*CYC edges after the accepting edge.
        always_comb begin
            dur_d      = sat_dur(dur_i[c*W +: W]);
            start_ok_d = start_i[c] && (dur_d != '0);
            expire_d   = (state_q == RUNNING) && (pre_q == PRE_LAST) &&
                         (us_q == dur_q - 1'b1);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                pre_q   <= '0;
                us_q    <= '0;
                dur_q   <= '0;
                mode_q  <= 1'b0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
                if (stop_i[c]) begin
                    state_q <= IDLE;
                    pre_q   <= '0;
                    us_q    <= '0;
                end else if (start_ok_d) begin
                    // Start or retrigger: a coincident expiry is dropped.
                    state_q <= RUNNING;
                    pre_q   <= '0;
                    us_q    <= '0;
                    dur_q   <= dur_d;
                    mode_q  <= periodic_i[c];
                end else begin
                    err_q <= start_i[c];
                    if (state_q == RUNNING) begin
                        if (expire_d) begin
                            done_q <= 1'b1;
                            pre_q  <= '0;
                            us_q   <= '0;
                            if (!mode_q) begin
                                state_q <= IDLE;
                            end
                        end else if (pre_q == PRE_LAST) begin
                            pre_q <= '0;
                            us_q  <= us_q + 1'b1;
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                    end
                end
            end
        end

        assign busy_o[c] = (state_q == RUNNING);
        assign done_o[c] = done_q;
        assign err_o[c]  = err_q;
    end

endmodule

// File: tb/tb_us_timer_bank.sv
// Scoreboard bench for us_timer_bank: a deadline-based reference model predicts
// busy/done/err per edge; a negedge monitor pops and compares.
module tb_us_timer_bank;

    localparam int CLK_FREQ = 10_000_000;
    localparam int NUM_CH   = 4;
    localparam int MAX_US   = 1000;
    localparam int W        = $clog2(MAX_US + 1);
    localparam int CYC      = CLK_FREQ / 1_000_000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM_CH-1:0]   start_i = '0;
    logic [NUM_CH-1:0]   stop_i = '0;
    logic [NUM_CH-1:0]   periodic_i = '0;
    logic [NUM_CH*W-1:0] dur_i = '0;
    logic [NUM_CH-1:0]   busy_o;
    logic [NUM_CH-1:0]   done_o;
    logic [NUM_CH-1:0]   err_o;

    always #5 clk = ~clk;

    us_timer_bank #(
        .CLK_FREQ(CLK_FREQ),
        .NUM_CH  (NUM_CH),
        .MAX_US  (MAX_US)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .periodic_i(periodic_i),
        .dur_i     (dur_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] busy;
        logic [NUM_CH-1:0] done;
        logic [NUM_CH-1:0] err;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;

    // Reference model: each running channel holds an absolute deadline (edge index).
    bit     m_busy[NUM_CH];
    bit     m_per[NUM_CH];
    longint m_nxt[NUM_CH];
    longint m_len[NUM_CH];
    longint edge_n = 0;

    function automatic int sat(input int d);
        return (d > MAX_US) ? MAX_US : d;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = '0;
        edge_n++;
        for (int c = 0; c < NUM_CH; c++) begin
            int d;
            d = sat(int'(dur_i[c*W +: W]));
            if (!rst_n) begin
                m_busy[c] = 1'b0;
            end else if (stop_i[c]) begin
                m_busy[c] = 1'b0;
            end else if (start_i[c] && d > 0) begin
                m_busy[c] = 1'b1;
                m_per[c]  = periodic_i[c];
                m_len[c]  = longint'(d) * CYC;
                m_nxt[c]  = edge_n + m_len[c];
            end else begin
                e.err[c] = start_i[c];
                if (m_busy[c] && edge_n == m_nxt[c]) begin
                    e.done[c] = 1'b1;
                    if (m_per[c]) m_nxt[c] = m_nxt[c] + m_len[c];
                    else m_busy[c] = 1'b0;
                end
            end
            e.busy[c] = m_busy[c];
        end
        exp_q.push_back(e);
    end

    task automatic cmp(input string nm, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t got %b expected %b", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            cmp("reset_busy", busy_o, '0);
            cmp("reset_done", done_o, '0);
            cmp("reset_err", err_o, '0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("busy", busy_o, e.busy);
            cmp("done", done_o, e.done);
            cmp("err", err_o, e.err);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_dur(input int c, input int d);
        dur_i[c*W +: W] = W'(d);
    endtask

    initial begin
        step(3);
        // First start lands on the first edge after reset release.
        rst_n = 1'b1;
        start_i[0] = 1'b1; periodic_i[0] = 1'b0; set_dur(0, 3);
        step(1);
        start_i = '0;
        step(35);

        start_i[1] = 1'b1; periodic_i[1] = 1'b1; set_dur(1, 2);
        step(1);
        start_i = '0;
        step(49);
        stop_i[1] = 1'b1;
        step(1);
        stop_i = '0;
        step(20);

        start_i[2] = 1'b1; periodic_i[2] = 1'b0; set_dur(2, 5);
        step(1);
        start_i = '0;
        step(44);
        start_i[2] = 1'b1; set_dur(2, 1);
        step(1);
        start_i = '0;
        step(15);
        start_i[2] = 1'b1; set_dur(2, 5);
        step(1);
        start_i = '0;
        step(3);
        start_i[2] = 1'b1; set_dur(2, 0);
        step(1);
        start_i = '0;
        step(60);

        start_i[3] = 1'b1; periodic_i[3] = 1'b0; set_dur(3, (1 << W) - 1);
        step(1);
        start_i = '0;
        step(10005);
        start_i[3] = 1'b1; stop_i[3] = 1'b1; set_dur(3, 4);
        step(1);
        start_i[3] = 1'b1; stop_i[3] = 1'b1; set_dur(3, 0);
        step(1);
        start_i = '0; stop_i = '0;
        step(5);

        // Re-arm one-shot on the idle cycle right after expiry.
        start_i[0] = 1'b1; periodic_i[0] = 1'b0; set_dur(0, 1);
        step(1);
        start_i = '0;
        step(10);
        start_i[0] = 1'b1;
        step(1);
        start_i = '0;
        step(15);

        periodic_i = '0;
        for (int c = 0; c < NUM_CH; c++) set_dur(c, c + 1);
        start_i = '1;
        step(1);
        start_i = '0;
        step(24);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(60);

        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                start_i[c]    = ($urandom_range(0, 19) == 0);
                stop_i[c]     = ($urandom_range(0, 39) == 0);
                periodic_i[c] = $urandom_range(0, 1);
                if ($urandom_range(0, 49) == 0) set_dur(c, $urandom_range(MAX_US - 2, (1 << W) - 1));
                else set_dur(c, $urandom_range(0, 6));
            end
            step(1);
        end
        start_i = '0; stop_i = '0;
        step(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
